// File: rtl/pragmatic_term_encoder_if.sv
// Weight-in / beat-out handshake bundle for pragmatic_term_encoder.
// master = weight producer and beat consumer side, slave = the encoder.
interface pragmatic_term_encoder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 16
);
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_in;
    logic                                  w_valid;
    logic                                  w_ready;
    logic [VEC_LENGTH-1:0][1:0]            shift_1st_sel;
    logic [VEC_LENGTH-1:0]                 shift_1st_en;
    logic [VEC_LENGTH-1:0]                 is_neg;
    logic [2:0]                            shift_2nd_sel;
    logic                                  shift_2nd_en;
    logic                                  out_valid;
    logic                                  out_last;
    logic                                  out_ready;

    modport master (
        output w_in, w_valid, out_ready,
        input  w_ready, shift_1st_sel, shift_1st_en, is_neg,
               shift_2nd_sel, shift_2nd_en, out_valid, out_last
    );

    modport slave (
        input  w_in, w_valid, out_ready,
        output w_ready, shift_1st_sel, shift_1st_en, is_neg,
               shift_2nd_sel, shift_2nd_en, out_valid, out_last
    );
endinterface

// File: rtl/pragmatic_term_encoder.sv
// Serializes a weight vector's power-of-two terms into Pragmatic MAC control beats.
// Define PRAGMATIC_ENC_CSD_EN for canonical-signed-digit recoding (default: sign-magnitude).

module pte_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic                  adv,
    input  logic [DATA_WIDTH-1:0] w,
    input  logic [2:0]            p,
    output logic [2:0]            pos,
    output logic                  nonempty,
    output logic                  en_next,
    output logic                  rem_empty,
    output logic [1:0]            sel_q,
    output logic                  en_q,
    output logic                  neg_q
);
    logic [7:0] mag, rec_mask, rec_neg;
    logic [7:0] pend_mask, pend_neg;
    logic [7:0] src_mask, src_neg, rem;
    logic [2:0] diff;

    assign mag = w[7] ? (~w + 8'd1) : w;

`ifdef PRAGMATIC_ENC_CSD_EN
    // NAF of |w| via the (3x ^ x) trick; a negative weight flips every digit's sign.
    logic [7:0] xh, x3, c, np, nm;
    assign xh       = mag >> 1;
    assign x3       = mag + xh;
    assign c        = xh ^ x3;
    assign np       = x3 & c;
    assign nm       = xh & c;
    assign rec_mask = np | nm;
    assign rec_neg  = w[7] ? np : nm;
`else
    assign rec_mask = mag;
    assign rec_neg  = {8{w[7]}};
`endif

    assign src_mask = load ? rec_mask : pend_mask;
    assign src_neg  = load ? rec_neg  : pend_neg;
    assign nonempty = |src_mask;

    always_comb begin
        pos = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (src_mask[i]) pos = 3'(i);
    end

    // p is the minimum over nonempty lanes, so pos - p never wraps here
    assign diff      = pos - p;
    assign en_next   = nonempty & ~diff[2];
    assign rem       = src_mask & ~(8'(en_next) << pos);
    assign rem_empty = ~|rem;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_mask <= '0;
            pend_neg  <= '0;
            sel_q     <= '0;
            en_q      <= 1'b0;
            neg_q     <= 1'b0;
        end else if (adv) begin
            pend_mask <= rem;
            pend_neg  <= src_neg;
            en_q      <= en_next;
            sel_q     <= en_next ? diff[1:0] : 2'd0;
            neg_q     <= en_next & src_neg[pos];
        end
    end
endmodule

module pragmatic_term_encoder #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pragmatic_term_encoder_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                     state;
    logic                       load, accept, adv;
    logic [2:0]                 p;
    logic [VEC_LENGTH-1:0][2:0] pos;
    logic [VEC_LENGTH-1:0]      nonempty, en_next, rem_empty;
    logic [VEC_LENGTH-1:0][1:0] sel_q;
    logic [VEC_LENGTH-1:0]      en_q, neg_q;
    logic                       out_valid_q, out_last_q, s2_en_q;
    logic [2:0]                 s2_sel_q;

    // Pending registers hold what remains after the beat currently presented,
    // so each beat is computed one cycle early and the outputs stay registered.
    assign load   = bus.w_valid & bus.w_ready;
    assign accept = out_valid_q & bus.out_ready;
    assign adv    = load | accept;

    assign bus.w_ready = reset_n & ((state == IDLE) | (out_last_q & bus.out_ready));

    always_comb begin
        p = 3'd7;
        for (int i = 0; i < VEC_LENGTH; i++)
            if (nonempty[i] && pos[i] < p) p = pos[i];
        if (!(|nonempty)) p = 3'd0;
    end

    for (genvar g = 0; g < VEC_LENGTH; g++) begin : g_lane
        pte_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .load      (load),
            .adv       (adv),
            .w         (bus.w_in[g]),
            .p         (p),
            .pos       (pos[g]),
            .nonempty  (nonempty[g]),
            .en_next   (en_next[g]),
            .rem_empty (rem_empty[g]),
            .sel_q     (sel_q[g]),
            .en_q      (en_q[g]),
            .neg_q     (neg_q[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            s2_sel_q    <= 3'd0;
            s2_en_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    state       <= BUSY;
                    out_valid_q <= 1'b1;
                    out_last_q  <= &rem_empty;
                    s2_sel_q    <= p;
                    s2_en_q     <= |en_next;
                end
                BUSY: if (accept) begin
                    if (load || !out_last_q) begin
                        out_last_q <= &rem_empty;
                        s2_sel_q   <= p;
                        s2_en_q    <= |en_next;
                    end else begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        s2_sel_q    <= 3'd0;
                        s2_en_q     <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.shift_1st_sel = sel_q;
    assign bus.shift_1st_en  = en_q;
    assign bus.is_neg        = neg_q;
    assign bus.shift_2nd_sel = s2_sel_q;
    assign bus.shift_2nd_en  = s2_en_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_last      = out_last_q;
endmodule

// File: tb/tb_pragmatic_term_encoder.sv
// Randomized bench for pragmatic_term_encoder: a digit-list reference model
// expands each accepted vector into its expected beat sequence.
module tb_pragmatic_term_encoder;
    localparam int VL = 16;

    typedef logic [VL-1:0][7:0] vec_t;
    typedef struct {
        logic [VL-1:0]      en;
        logic [VL-1:0][1:0] sel;
        logic [VL-1:0]      neg;
        logic [2:0]         s2;
        logic               s2en;
        logic               last;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pragmatic_term_encoder_if #(.DATA_WIDTH(8), .VEC_LENGTH(VL)) bus ();
    pragmatic_term_encoder #(.DATA_WIDTH(8), .VEC_LENGTH(VL)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    beat_t exp_q[$];
    vec_t  stim_q[$];
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Each lane becomes a list of signed digits; beats are peeled off from the low end.
    function automatic void expand(input vec_t w);
        int    d [VL][8];
        int    lo [VL];
        int    x, m, dd, p;
        bit    any, remain;
        beat_t b;
        any = 0;
        for (int l = 0; l < VL; l++) begin
            x = int'($signed(w[l]));
`ifdef PRAGMATIC_ENC_CSD_EN
            for (int i = 0; i < 8; i++) begin
                dd = 0;
                if (x % 2 != 0) dd = ((x & 3) == 1) ? 1 : -1;
                d[l][i] = dd;
                x = (x - dd) / 2;
            end
`else
            m = (x < 0) ? -x : x;
            for (int i = 0; i < 8; i++) d[l][i] = m[i] ? ((x < 0) ? -1 : 1) : 0;
`endif
            for (int i = 0; i < 8; i++) if (d[l][i] != 0) any = 1;
        end
        if (!any) begin
            b = '{en: '0, sel: '0, neg: '0, s2: 3'd0, s2en: 1'b0, last: 1'b1};
            exp_q.push_back(b);
            return;
        end
        do begin
            p = 8;
            for (int l = 0; l < VL; l++) begin
                lo[l] = 8;
                for (int i = 7; i >= 0; i--) if (d[l][i] != 0) lo[l] = i;
                if (lo[l] < p) p = lo[l];
            end
            b = '{en: '0, sel: '0, neg: '0, s2: 3'(p), s2en: 1'b0, last: 1'b0};
            for (int l = 0; l < VL; l++) begin
                if (lo[l] < 8 && lo[l] - p <= 3) begin
                    b.en[l]  = 1'b1;
                    b.sel[l] = 2'(lo[l] - p);
                    b.neg[l] = (d[l][lo[l]] < 0);
                    b.s2en   = 1'b1;
                    d[l][lo[l]] = 0;
                end
            end
            remain = 0;
            for (int l = 0; l < VL; l++)
                for (int i = 0; i < 8; i++) if (d[l][i] != 0) remain = 1;
            b.last = !remain;
            exp_q.push_back(b);
        end while (remain);
    endfunction

    // One clock: drive at negedge, check what the DUT shows, update the model at posedge.
    task automatic cycle(input bit wv, input vec_t w, input bit ordy, output bit took);
        bit acc_out;
        bus.w_valid   = wv;
        bus.w_in      = w;
        bus.out_ready = ordy;
        #1;
        check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        check("w_ready", 64'(bus.w_ready),
              64'((exp_q.size() == 0) ? 1'b1 : (exp_q[0].last & ordy)));
        if (bus.out_valid && exp_q.size() != 0) begin
            check("shift_1st_en",  64'(bus.shift_1st_en),  64'(exp_q[0].en));
            check("shift_1st_sel", 64'(bus.shift_1st_sel), 64'(exp_q[0].sel));
            check("is_neg",        64'(bus.is_neg),        64'(exp_q[0].neg));
            check("shift_2nd_sel", 64'(bus.shift_2nd_sel), 64'(exp_q[0].s2));
            check("shift_2nd_en",  64'(bus.shift_2nd_en),  64'(exp_q[0].s2en));
            check("out_last",      64'(bus.out_last),      64'(exp_q[0].last));
        end
        acc_out = bus.out_valid & ordy;
        took    = wv & bus.w_ready;
        @(posedge clk);
        if (acc_out && exp_q.size() != 0) void'(exp_q.pop_front());
        if (took) expand(w);
        @(negedge clk);
    endtask

    task automatic run(input int pv, input int pr, input int budget);
        bit   took, hold, wv;
        vec_t w;
        int   n;
        hold = 0;
        n = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            wv = (stim_q.size() != 0) && (hold || $urandom_range(99) < pv);
            w  = (stim_q.size() != 0) ? stim_q[0] : '0;
            cycle(wv, w, $urandom_range(99) < pr, took);
            hold = wv && !took;
            if (took) void'(stim_q.pop_front());
            n++;
        end
        check("drain", 64'(stim_q.size() + exp_q.size()), 64'd0);
        stim_q.delete();
        exp_q.delete();
    endtask

    task automatic load_one(input vec_t v);
        bit took;
        took = 0;
        for (int i = 0; i < 10 && !took; i++) cycle(1'b1, v, 1'b1, took);
        check("load_one", 64'(took), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_last"},  64'(bus.out_last),  64'd0);
        check({tag, "_en"},        64'(bus.shift_1st_en),  64'd0);
        check({tag, "_sel"},       64'(bus.shift_1st_sel), 64'd0);
        check({tag, "_neg"},       64'(bus.is_neg),        64'd0);
        check({tag, "_s2sel"},     64'(bus.shift_2nd_sel), 64'd0);
        check({tag, "_s2en"},      64'(bus.shift_2nd_en),  64'd0);
        check({tag, "_w_ready"},   64'(bus.w_ready),       64'd0);
    endtask

    initial begin
        vec_t v;
        bit   took;
        bus.w_in = '0;
        bus.w_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors from the behaviour description, back-to-back.
        v = '0; v[0] = 8'd5; v[1] = 8'hFA;          stim_q.push_back(v);
        v = '0; v[0] = 8'd1; v[1] = 8'd64;          stim_q.push_back(v);
        v = '0; v[3] = 8'h80;                       stim_q.push_back(v);
        v = '0;                                     stim_q.push_back(v);
        v = '0; v[0] = 8'd7;                        stim_q.push_back(v);
        v = '0; v[0] = 8'd127; v[15] = 8'h81;       stim_q.push_back(v);
        run(100, 100, 2000);

        // Stall mid-vector for 5 cycles, then finish with the next vector queued.
        v = '0; v[0] = 8'd85; v[2] = 8'h81; v[9] = 8'hC3;
        load_one(v);
        cycle(1'b0, '0, 1'b1, took);
        repeat (5) cycle(1'b0, '0, 1'b0, took);
        v = '0; v[5] = 8'd12;
        stim_q.push_back(v);
        run(100, 100, 2000);

        // Reset mid-vector discards the in-flight work.
        v = '0; v[0] = 8'd85; v[1] = 8'hAA;
        load_one(v);
        cycle(1'b0, '0, 1'b1, took);
        reset_n = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        v = '0; v[0] = 8'd5; v[1] = 8'hFA;
        stim_q.push_back(v);
        run(100, 100, 200);

        // Random vectors with random handshakes.
        for (int k = 0; k < 60; k++) begin
            for (int l = 0; l < VL; l++) begin
                case ($urandom_range(3))
                    0:       v[l] = 8'd0;
                    1:       v[l] = 8'(1 << $urandom_range(7));
                    default: v[l] = 8'($urandom);
                endcase
            end
            stim_q.push_back(v);
        end
        run(60, 70, 40000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
